// File: rtl/mem_stage_if.sv
// Bundles the EX/MEM inputs, data-memory response and MEM/WB outputs of mem_stage.
// Latency: none; this is a plain signal bundle.
// Backpressure: ready is driven by the stage back toward the upstream pipeline.
interface mem_stage_if;
  logic [31:0] PC_EX;
  logic [31:0] IR_EX;
  logic [4:0]  rd_addr_EX;
  logic [31:0] rd_data_EX;
  logic        rd_access_EX;
  logic [2:0]  MEM_op_EX;
  logic        dmem_access_EX;
  logic        illegal_inst_EX;
  logic        misaligned_addr_EX;
  logic [31:0] dmem_din;
  logic        dmem_valid;
  logic        ready;
  logic [31:0] PC_MEM;
  logic [31:0] IR_MEM;
  logic [4:0]  rd_addr_MEM;
  logic [31:0] rd_data_MEM;
  logic        rd_access_MEM;
  logic        exception_MEM;
  logic [3:0]  cause_MEM;

  // Pipeline / memory side: drives EX/MEM contents and memory response.
  modport master (
    output PC_EX, IR_EX, rd_addr_EX, rd_data_EX, rd_access_EX, MEM_op_EX,
           dmem_access_EX, illegal_inst_EX, misaligned_addr_EX, dmem_din, dmem_valid,
    input  ready, PC_MEM, IR_MEM, rd_addr_MEM, rd_data_MEM, rd_access_MEM,
           exception_MEM, cause_MEM
  );

  // The memory stage itself.
  modport slave (
    input  PC_EX, IR_EX, rd_addr_EX, rd_data_EX, rd_access_EX, MEM_op_EX,
           dmem_access_EX, illegal_inst_EX, misaligned_addr_EX, dmem_din, dmem_valid,
    output ready, PC_MEM, IR_MEM, rd_addr_MEM, rd_data_MEM, rd_access_MEM,
           exception_MEM, cause_MEM
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: formats load data, waits on dmem_valid, raises prioritised faults.
// Latency: 1 cycle EX/MEM -> MEM/WB; each cycle without dmem_valid adds one stall cycle.
// Backpressure: ready=0 (combinational) stalls upstream until response or TIMEOUT.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        reset,
  input logic        clear,
  mem_stage_if.slave bus
);
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LBU = 3'd3;
  localparam logic [2:0] MEM_LHU = 3'd4;

  typedef enum logic {RUN, WAIT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        is_load;
  logic        fault;
  logic        mem_instr;
  logic        cnt_done;
  logic        timeout;
  logic        ready_c;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] wb_data;

  // Classify the instruction and decide whether the stage can complete this cycle.
  always_comb begin
    is_load   = (bus.MEM_op_EX == MEM_LB)  || (bus.MEM_op_EX == MEM_LH) ||
                (bus.MEM_op_EX == MEM_LW)  || (bus.MEM_op_EX == MEM_LBU) ||
                (bus.MEM_op_EX == MEM_LHU);
    fault     = bus.illegal_inst_EX || bus.misaligned_addr_EX;
    // Faulted instructions never touch the memory handshake.
    mem_instr = bus.dmem_access_EX && !fault;
    cnt_done  = (cnt == 8'(TIMEOUT));
    // A response in the same cycle as the last count wins over the timeout.
    timeout   = (state == WAIT) && !bus.dmem_valid && cnt_done;
    if (state == RUN) ready_c = !mem_instr || bus.dmem_valid;
    else              ready_c = bus.dmem_valid || cnt_done;
  end

  // Extract the addressed byte / halfword from the word-aligned read data.
  always_comb begin
    sel_byte = bus.dmem_din[7:0];
    sel_half = bus.dmem_din[15:0];
    case (bus.rd_data_EX[1:0])
      2'd0: begin sel_byte = bus.dmem_din[7:0];   sel_half = bus.dmem_din[15:0];  end
      2'd1: begin sel_byte = bus.dmem_din[15:8];  sel_half = bus.dmem_din[23:8];  end
      2'd2: begin sel_byte = bus.dmem_din[23:16]; sel_half = bus.dmem_din[31:16]; end
      default: begin
        // off 3 halfword is misaligned and faults upstream; value is don't-care.
        sel_byte = bus.dmem_din[31:24];
        sel_half = {8'h00, bus.dmem_din[31:24]};
      end
    endcase
    wb_data = bus.rd_data_EX;
    if (mem_instr && is_load) begin
      case (bus.MEM_op_EX)
        MEM_LB:  wb_data = {{24{sel_byte[7]}}, sel_byte};
        MEM_LBU: wb_data = {24'h000000, sel_byte};
        MEM_LH:  wb_data = {{16{sel_half[15]}}, sel_half};
        MEM_LHU: wb_data = {16'h0000, sel_half};
        default: wb_data = bus.dmem_din;
      endcase
    end
  end

  assign bus.ready = ready_c;

  // Wait FSM and MEM/WB registers; registers load only when the stage completes.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state             <= RUN;
      cnt               <= 8'd0;
      bus.PC_MEM        <= 32'd0;
      bus.IR_MEM        <= 32'd0;
      bus.rd_addr_MEM   <= 5'd0;
      bus.rd_data_MEM   <= 32'd0;
      bus.rd_access_MEM <= 1'b0;
      bus.exception_MEM <= 1'b0;
      bus.cause_MEM     <= 4'd0;
    end else begin
      if (ready_c) begin
        bus.PC_MEM      <= bus.PC_EX;
        bus.IR_MEM      <= bus.IR_EX;
        bus.rd_addr_MEM <= bus.rd_addr_EX;
        bus.rd_data_MEM <= wb_data;
        if (bus.illegal_inst_EX) begin
          bus.rd_access_MEM <= 1'b0;
          bus.exception_MEM <= 1'b1;
          bus.cause_MEM     <= 4'd2;
        end else if (bus.misaligned_addr_EX) begin
          bus.rd_access_MEM <= 1'b0;
          bus.exception_MEM <= 1'b1;
          bus.cause_MEM     <= is_load ? 4'd4 : 4'd6;
        end else if (timeout) begin
          bus.rd_access_MEM <= 1'b0;
          bus.exception_MEM <= 1'b1;
          bus.cause_MEM     <= is_load ? 4'd5 : 4'd7;
        end else begin
          bus.rd_access_MEM <= bus.rd_access_EX;
          bus.exception_MEM <= 1'b0;
          bus.cause_MEM     <= 4'd0;
        end
      end
      case (state)
        RUN: begin
          if (mem_instr && !bus.dmem_valid) begin
            state <= WAIT;
            cnt   <= 8'd1;
          end
        end
        default: begin
          if (ready_c) begin
            state <= RUN;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each check is an immediate assertion that counts and reports failures.
module tb_mem_stage;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;
  localparam logic [2:0] SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                        input logic rdacc, input logic [2:0] op, input logic acc,
                        input logic ill, input logic mis);
    bus.PC_EX              = pc;
    bus.IR_EX              = pc ^ 32'h00A5_0000;
    bus.rd_addr_EX         = rd;
    bus.rd_data_EX         = data;
    bus.rd_access_EX       = rdacc;
    bus.MEM_op_EX          = op;
    bus.dmem_access_EX     = acc;
    bus.illegal_inst_EX    = ill;
    bus.misaligned_addr_EX = mis;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"},    bus.PC_MEM, 32'd0);
    chk({tag, "_ir"},    bus.IR_MEM, 32'd0);
    chk({tag, "_rd"},    {27'd0, bus.rd_addr_MEM}, 32'd0);
    chk({tag, "_data"},  bus.rd_data_MEM, 32'd0);
    chk({tag, "_acc"},   {31'd0, bus.rd_access_MEM}, 32'd0);
    chk({tag, "_exc"},   {31'd0, bus.exception_MEM}, 32'd0);
    chk({tag, "_cause"}, {28'd0, bus.cause_MEM}, 32'd0);
  endtask

  // Start a LW that never gets a response, then abort it in the second WAIT cycle.
  task automatic abort_access(input string tag, input logic use_reset);
    set_ex(32'h500, 5'd4, 32'h6000, 1'b1, LW, 1'b1, 1'b0, 1'b0);
    bus.dmem_valid = 1'b0;
    #1 chk({tag, "_stall0"}, {31'd0, bus.ready}, 32'd0);
    cyc();  // first WAIT cycle
    cyc();  // second WAIT cycle
    chk({tag, "_stall2"}, {31'd0, bus.ready}, 32'd0);
    if (use_reset) reset = 1'b1;
    else           clear = 1'b1;
    bus.dmem_valid = 1'b1;  // dropped by the abort
    bus.dmem_din   = 32'hFFFF_FFFF;
    cyc();
    reset = 1'b0;
    clear = 1'b0;
    bus.dmem_valid = 1'b0;
    set_ex(32'h0, 5'd0, 32'h0, 1'b0, LB, 1'b0, 1'b0, 1'b0);
    #1;
    chk_all_zero(tag);
    chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    // A new unanswered access must stall exactly TIMEOUT cycles (counter restarted).
    set_ex(32'h504, 5'd4, 32'h6000, 1'b1, LW, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 chk({tag, "_restall"}, {31'd0, bus.ready}, 32'd0);
      cyc();
    end
    chk({tag, "_reto_rdy"}, {31'd0, bus.ready}, 32'd1);
    cyc();
    chk({tag, "_reto_cause"}, {28'd0, bus.cause_MEM}, 32'd5);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    set_ex(32'h0, 5'd0, 32'h0, 1'b0, LB, 1'b0, 1'b0, 1'b0);
    bus.dmem_din   = 32'h0;
    bus.dmem_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk_all_zero("reset");
    chk("reset_ready", {31'd0, bus.ready}, 32'd1);

    // LB, offset 3, sign extension, response already present.
    set_ex(32'h100, 5'd5, 32'h1003, 1'b1, LB, 1'b1, 1'b0, 1'b0);
    bus.dmem_din   = 32'h80FF_7F00;
    bus.dmem_valid = 1'b1;
    #1 chk("lb_ready", {31'd0, bus.ready}, 32'd1);
    cyc();
    chk("lb_data", bus.rd_data_MEM, 32'hFFFF_FF80);
    chk("lb_acc",  {31'd0, bus.rd_access_MEM}, 32'd1);
    chk("lb_rd",   {27'd0, bus.rd_addr_MEM}, 32'd5);
    chk("lb_pc",   bus.PC_MEM, 32'h100);

    // LHU offset 2.
    set_ex(32'h104, 5'd6, 32'h2002, 1'b1, LHU, 1'b1, 1'b0, 1'b0);
    bus.dmem_din = 32'hBEEF_1234;
    #1 chk("lhu_ready", {31'd0, bus.ready}, 32'd1);
    cyc();
    chk("lhu_data", bus.rd_data_MEM, 32'h0000_BEEF);

    // LW.
    set_ex(32'h108, 5'd7, 32'h2000, 1'b1, LW, 1'b1, 1'b0, 1'b0);
    bus.dmem_din = 32'hDEAD_BEEF;
    cyc();
    chk("lw_data", bus.rd_data_MEM, 32'hDEAD_BEEF);

    // LH offset 0 with negative half, LBU offset 1.
    set_ex(32'h10C, 5'd8, 32'h2000, 1'b1, LH, 1'b1, 1'b0, 1'b0);
    bus.dmem_din = 32'h1234_8001;
    cyc();
    chk("lh_data", bus.rd_data_MEM, 32'hFFFF_8001);
    set_ex(32'h110, 5'd8, 32'h2001, 1'b1, LBU, 1'b1, 1'b0, 1'b0);
    bus.dmem_din = 32'h0000_9A00;
    cyc();
    chk("lbu_data", bus.rd_data_MEM, 32'h0000_009A);

    // LW with response delayed 3 cycles: exactly 3 stall cycles, outputs held.
    set_ex(32'h200, 5'd9, 32'h3000, 1'b1, LW, 1'b1, 1'b0, 1'b0);
    bus.dmem_din   = 32'h1234_5678;
    bus.dmem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_ready", {31'd0, bus.ready}, 32'd0);
      chk("wait_hold_pc", bus.PC_MEM, 32'h110);
      chk("wait_hold_data", bus.rd_data_MEM, 32'h0000_009A);
      cyc();
    end
    bus.dmem_valid = 1'b1;
    #1 chk("wait_done_ready", {31'd0, bus.ready}, 32'd1);
    cyc();
    chk("wait_data", bus.rd_data_MEM, 32'h1234_5678);
    chk("wait_pc",   bus.PC_MEM, 32'h200);

    // SW never acknowledged: 4 stall cycles then bus fault, cause 7.
    set_ex(32'h300, 5'd0, 32'h4000, 1'b0, SW, 1'b1, 1'b0, 1'b0);
    bus.dmem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("sw_to_stall", {31'd0, bus.ready}, 32'd0);
      cyc();
    end
    chk("sw_to_ready", {31'd0, bus.ready}, 32'd1);
    cyc();
    chk("sw_to_exc",   {31'd0, bus.exception_MEM}, 32'd1);
    chk("sw_to_cause", {28'd0, bus.cause_MEM}, 32'd7);
    chk("sw_to_acc",   {31'd0, bus.rd_access_MEM}, 32'd0);
    chk("sw_to_pc",    bus.PC_MEM, 32'h300);

    // Load timeout: cause 5, no writeback.
    set_ex(32'h304, 5'd3, 32'h4000, 1'b1, LW, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("lw_to_stall", {31'd0, bus.ready}, 32'd0);
      cyc();
    end
    cyc();
    chk("lw_to_exc",   {31'd0, bus.exception_MEM}, 32'd1);
    chk("lw_to_cause", {28'd0, bus.cause_MEM}, 32'd5);
    chk("lw_to_acc",   {31'd0, bus.rd_access_MEM}, 32'd0);

    // Response arriving exactly at the last count is a success.
    set_ex(32'h308, 5'd3, 32'h4000, 1'b1, LW, 1'b1, 1'b0, 1'b0);
    bus.dmem_din = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) cyc();
    bus.dmem_valid = 1'b1;
    cyc();
    chk("edge_exc",  {31'd0, bus.exception_MEM}, 32'd0);
    chk("edge_data", bus.rd_data_MEM, 32'h0BAD_F00D);
    chk("edge_acc",  {31'd0, bus.rd_access_MEM}, 32'd1);

    // Illegal + misaligned together: illegal wins, no stall.
    set_ex(32'h400, 5'd2, 32'h5001, 1'b1, LW, 1'b1, 1'b1, 1'b1);
    bus.dmem_valid = 1'b0;
    #1 chk("ill_ready", {31'd0, bus.ready}, 32'd1);
    cyc();
    chk("ill_cause", {28'd0, bus.cause_MEM}, 32'd2);
    chk("ill_exc",   {31'd0, bus.exception_MEM}, 32'd1);
    chk("ill_acc",   {31'd0, bus.rd_access_MEM}, 32'd0);

    // Misaligned LH alone: cause 4, no stall.
    set_ex(32'h404, 5'd2, 32'h5003, 1'b1, LH, 1'b1, 1'b0, 1'b1);
    #1 chk("mis_ready", {31'd0, bus.ready}, 32'd1);
    cyc();
    chk("mis_cause", {28'd0, bus.cause_MEM}, 32'd4);

    // Misaligned SH: cause 6.
    set_ex(32'h408, 5'd0, 32'h5001, 1'b0, SH, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("mis_st_cause", {28'd0, bus.cause_MEM}, 32'd6);

    // Non-memory instruction with stray dmem_valid: ALU result written back.
    set_ex(32'h40C, 5'd9, 32'h0000_CAFE, 1'b1, LB, 1'b0, 1'b0, 1'b0);
    bus.dmem_valid = 1'b1;
    bus.dmem_din   = 32'h1111_1111;
    cyc();
    chk("alu_data", bus.rd_data_MEM, 32'h0000_CAFE);
    chk("alu_exc",  {31'd0, bus.exception_MEM}, 32'd0);
    chk("alu_acc",  {31'd0, bus.rd_access_MEM}, 32'd1);

    abort_access("clear", 1'b0);
    abort_access("rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
